clk_div_multi: RTL

Multi-channel programmable clock divider, successor to the fixed single-output divider. Generates NUM_CH independent divided outputs from one system clock. Each channel has a runtime-programmable period and high time, an enable, and a one-cycle period-start tick. Divisor changes are glitch-free because a new setting takes effect only at a period boundary. Sits between the board oscillator domain and slow peripherals (FIFO test drivers, LED/UART strobes); outputs are intended as clock enables or low-speed fabric clocks.

---
 rtl/clk_div_multi_if.sv | 25 ++
 rtl/clk_div_multi.sv | 120 ++++++++++++
 2 files changed

// File: rtl/clk_div_multi_if.sv
// Configuration and output bundle for the multi-channel clock divider.
interface clk_div_multi_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32
);
   logic [NUM_CH-1:0] ch_en;
   logic              cfg_we;
   logic [3:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [CNT_W-1:0]  cfg_high;
   logic              cfg_err;
   logic [NUM_CH-1:0] cfg_pending;
   logic [NUM_CH-1:0] clock_out;
   logic [NUM_CH-1:0] tick_out;

   modport master (
      output ch_en, cfg_we, cfg_ch, cfg_div, cfg_high,
      input  cfg_err, cfg_pending, clock_out, tick_out
   );

   modport slave (
      input  ch_en, cfg_we, cfg_ch, cfg_div, cfg_high,
      output cfg_err, cfg_pending, clock_out, tick_out
   );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// A write to a running channel lands in a shadow copy and is promoted only at
// that channel's terminal count, so no period is ever truncated or stretched.
module clk_div_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 100000
) (
   input logic            clock_in,
   input logic            reset,
   clk_div_multi_if.slave bus
);

   localparam int unsigned CH_IDX_W = 4;

   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  div_a_q  [NUM_CH];
   logic [CNT_W-1:0]  div_a_d  [NUM_CH];
   logic [CNT_W-1:0]  high_a_q [NUM_CH];
   logic [CNT_W-1:0]  high_a_d [NUM_CH];
   logic [CNT_W-1:0]  div_s_q  [NUM_CH];
   logic [CNT_W-1:0]  div_s_d  [NUM_CH];
   logic [CNT_W-1:0]  high_s_q [NUM_CH];
   logic [CNT_W-1:0]  high_s_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic              err_q, err_d;

   logic [NUM_CH-1:0] term_c;
   logic [NUM_CH-1:0] wr_c;
   logic              reject_c;
   logic [CNT_W-1:0]  high_res_c;

   // Write validation, high-time resolution and per-channel next state.
   always_comb begin
      high_res_c = (bus.cfg_high == '0) ? (bus.cfg_div >> 1) : bus.cfg_high;
      reject_c   = bus.cfg_we &&
                   ((32'(bus.cfg_ch) >= NUM_CH) ||
                    (bus.cfg_div < CNT_W'(2)) ||
                    ((bus.cfg_high != '0) && (bus.cfg_high >= bus.cfg_div)));
      err_d      = reject_c;
      pend_d     = pend_q;
      clk_d      = clk_q;
      tick_d     = tick_q;
      term_c     = '0;
      wr_c       = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         cnt_d[c]    = cnt_q[c];
         div_a_d[c]  = div_a_q[c];
         high_a_d[c] = high_a_q[c];
         div_s_d[c]  = div_s_q[c];
         high_s_d[c] = high_s_q[c];

         term_c[c] = bus.ch_en[c] && (cnt_q[c] == (div_a_q[c] - CNT_W'(1)));
         wr_c[c]   = bus.cfg_we && !reject_c && (bus.cfg_ch == CH_IDX_W'(c));

         if (bus.ch_en[c]) begin
            clk_d[c]  = (cnt_q[c] < high_a_q[c]);
            tick_d[c] = (cnt_q[c] == '0);
            cnt_d[c]  = term_c[c] ? '0 : (cnt_q[c] + CNT_W'(1));
         end else begin
            clk_d[c]  = 1'b0;
            tick_d[c] = 1'b0;
            cnt_d[c]  = '0;
         end

         if (wr_c[c]) begin
            if (!bus.ch_en[c] || term_c[c]) begin
               // Idle channel or write on the boundary: take effect now.
               div_a_d[c]  = bus.cfg_div;
               high_a_d[c] = high_res_c;
               pend_d[c]   = 1'b0;
            end else begin
               div_s_d[c]  = bus.cfg_div;
               high_s_d[c] = high_res_c;
               pend_d[c]   = 1'b1;
            end
         end else if (term_c[c] && pend_q[c]) begin
            div_a_d[c]  = div_s_q[c];
            high_a_d[c] = high_s_q[c];
            pend_d[c]   = 1'b0;
         end
      end
   end

   // State registers with synchronous reset to the default divisor.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt_q[c]    <= '0;
            div_a_q[c]  <= CNT_W'(DEFAULT_DIV);
            high_a_q[c] <= CNT_W'(DEFAULT_DIV >> 1);
            div_s_q[c]  <= CNT_W'(DEFAULT_DIV);
            high_s_q[c] <= CNT_W'(DEFAULT_DIV >> 1);
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_a_q  <= div_a_d;
         high_a_q <= high_a_d;
         div_s_q  <= div_s_d;
         high_s_q <= high_s_d;
         pend_q   <= pend_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         err_q    <= err_d;
      end
   end

   assign bus.clock_out   = clk_q;
   assign bus.tick_out    = tick_q;
   assign bus.cfg_pending = pend_q;
   assign bus.cfg_err     = err_q;

endmodule
